ethernet_tx_arbiter: RTL and testbench

Shares the single transmit framer between the ARP and IP engines. Each engine requests the framer, streams its frame as 16-bit halfwords once granted, and the arbiter packs the halfwords into the 32-bit word stream, tags each frame with its EtherType, and enforces the inter-frame gap and a maximum frame length. It is the transmit-side counterpart of the receive header parser. It sits between the ARP/IP engines and the MAC transmit framer, which adds the preamble, addresses and CRC.

---
 rtl/ethernet_tx_arbiter_pkg.sv | 25 ++
 rtl/ethernet_tx_arbiter_if.sv | 44 ++++
 rtl/ethernet_tx_arbiter_halfword_packer.sv | 64 ++++++
 rtl/ethernet_tx_arbiter.sv | 124 ++++++++++++
 tb/tb_ethernet_tx_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ethernet_tx_arbiter_pkg.sv
// Shared constants and types for the transmit arbiter and its halfword packer.
// EtherType tags, FSM encoding and default sizing parameters.
package ethernet_tx_arbiter_pkg;

    localparam logic [15:0] ETH_TYPE_ARP = 16'h0806;
    localparam logic [15:0] ETH_TYPE_IP  = 16'h0800;

    localparam int unsigned DEFAULT_IFG     = 3;
    localparam int unsigned DEFAULT_MAXHALF = 750;

    localparam int unsigned HALF_W = 16;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        PASS,
        DRAIN,
        GAP
    } arb_state_t;

    function automatic logic [15:0] eth_type(input logic is_ip);
        return is_ip ? ETH_TYPE_IP : ETH_TYPE_ARP;
    endfunction

endpackage

// File: rtl/ethernet_tx_arbiter_if.sv
// Bundle of ARP/IP engine handshakes and the packed word stream to the MAC framer.
// master: the arbiter side; slave: the engines and MAC framer.
interface ethernet_tx_arbiter_if;

    logic        arpreq;
    logic        arpgrant;
    logic        arpvalid;
    logic        arpeof;
    logic [15:0] arpdata;
    logic        arpready;

    logic        ipreq;
    logic        ipgrant;
    logic        ipvalid;
    logic        ipeof;
    logic [15:0] ipdata;
    logic        ipready;

    logic        macready;
    logic        validout;
    logic        sofout;
    logic        eofout;
    logic [31:0] dataout;
    logic        oddout;
    logic [15:0] typeout;
    logic        lenerr;

    modport master (
        input  arpreq, arpvalid, arpeof, arpdata,
        input  ipreq, ipvalid, ipeof, ipdata,
        input  macready,
        output arpgrant, arpready, ipgrant, ipready,
        output validout, sofout, eofout, dataout, oddout, typeout, lenerr
    );

    modport slave (
        output arpreq, arpvalid, arpeof, arpdata,
        output ipreq, ipvalid, ipeof, ipdata,
        output macready,
        input  arpgrant, arpready, ipgrant, ipready,
        input  validout, sofout, eofout, dataout, oddout, typeout, lenerr
    );

endinterface

// File: rtl/ethernet_tx_arbiter_halfword_packer.sv
// Packs a 16-bit halfword stream into 32-bit words (first halfword low) with sof/eof/odd flags.
// The output word is held while valid and not accepted downstream.
module halfword_packer
    import ethernet_tx_arbiter_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [HALF_W-1:0] in_data,
    input  logic              in_last,
    input  logic              out_ready,
    output logic              out_valid,
    output logic              out_sof,
    output logic              out_eof,
    output logic              out_odd,
    output logic [WORD_W-1:0] out_data
);

    logic              have_hold;
    logic [HALF_W-1:0] hold;
    logic              first_pending;
    logic              emit;
    logic              consume;

    // A word leaves on the second halfword, or early when the frame ends on an even slot.
    assign emit    = in_valid && (have_hold || in_last);
    assign consume = out_valid && out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            have_hold     <= 1'b0;
            hold          <= '0;
            first_pending <= 1'b1;
            out_valid     <= 1'b0;
            out_sof       <= 1'b0;
            out_eof       <= 1'b0;
            out_odd       <= 1'b0;
            out_data      <= '0;
        end else begin
            if (in_valid) begin
                have_hold <= !have_hold && !in_last;
                if (!have_hold) begin
                    hold <= in_data;
                end
            end

            if (emit) begin
                out_valid     <= 1'b1;
                out_sof       <= first_pending;
                out_eof       <= in_last;
                out_odd       <= !have_hold;
                out_data      <= have_hold ? {in_data, hold} : {{HALF_W{1'b0}}, in_data};
                first_pending <= in_last;
            end else if (consume) begin
                out_valid <= 1'b0;
                out_sof   <= 1'b0;
                out_eof   <= 1'b0;
                out_odd   <= 1'b0;
                out_data  <= '0;
            end
        end
    end

endmodule

// File: rtl/ethernet_tx_arbiter.sv
// Round-robin arbiter sharing the transmit framer between the ARP and IP engines.
// Tags frames with EtherType, enforces the inter-frame gap and truncates at MAXHALF.
module ethernet_tx_arbiter
    import ethernet_tx_arbiter_pkg::*;
#(
    parameter int unsigned IFG_CYCLES = DEFAULT_IFG,
    parameter int unsigned MAXHALF    = DEFAULT_MAXHALF
) (
    input  logic clock,
    input  logic reset,
    ethernet_tx_arbiter_if.master bus
);

    localparam int unsigned     HCW       = $clog2(MAXHALF + 1);
    localparam logic [HCW-1:0]  LAST_HALF = HCW'(MAXHALF - 1);
    localparam logic [3:0]      GAP_LAST  = 4'(IFG_CYCLES - 1);

    arb_state_t state;
    arb_state_t state_next;

    logic           last_ip;
    logic           owner_ip;
    logic [HCW-1:0] hcount;
    logic [3:0]     gap_cnt;

    logic        any_req;
    logic        pick_ip;
    logic        src_valid;
    logic        src_eof;
    logic [15:0] src_data;
    logic        src_ready;
    logic        accept;
    logic        trunc;

    assign any_req = bus.arpreq || bus.ipreq;
    // On a conflict the engine not served last wins; a lone requester always wins.
    assign pick_ip = bus.ipreq && (!bus.arpreq || !last_ip);

    assign src_valid = owner_ip ? bus.ipvalid : bus.arpvalid;
    assign src_eof   = owner_ip ? bus.ipeof   : bus.arpeof;
    assign src_data  = owner_ip ? bus.ipdata  : bus.arpdata;

    assign accept = (state == PASS) && src_valid && src_ready;
    assign trunc  = accept && !src_eof && (hcount == LAST_HALF);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = PASS;
            PASS:    if (trunc) state_next = DRAIN;
                     else if (accept && src_eof) state_next = GAP;
            DRAIN:   if (src_valid && src_eof) state_next = GAP;
            GAP:     if (!bus.validout && gap_cnt == GAP_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        src_ready = 1'b0;
        case (state)
            PASS:    src_ready = !bus.validout || bus.macready;
            DRAIN:   src_ready = 1'b1;
            default: src_ready = 1'b0;
        endcase
        bus.arpgrant = (state == PASS) && !owner_ip;
        bus.ipgrant  = (state == PASS) && owner_ip;
        bus.arpready = src_ready && !owner_ip;
        bus.ipready  = src_ready && owner_ip;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_ip     <= 1'b1;
            owner_ip    <= 1'b0;
            hcount      <= '0;
            gap_cnt     <= '0;
            bus.typeout <= '0;
            bus.lenerr  <= 1'b0;
        end else begin
            bus.lenerr <= trunc;

            if (state == IDLE && any_req) begin
                owner_ip    <= pick_ip;
                last_ip     <= pick_ip;
                bus.typeout <= eth_type(pick_ip);
                hcount      <= '0;
            end else if (accept) begin
                hcount <= hcount + 1'b1;
            end

            // The gap only runs once the final word has left the output register.
            if (state == GAP) begin
                if (!bus.validout) begin
                    gap_cnt <= gap_cnt + 4'd1;
                end
            end else begin
                gap_cnt <= '0;
            end
        end
    end

    halfword_packer u_packer (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (accept),
        .in_data   (src_data),
        .in_last   (src_eof || trunc),
        .out_ready (bus.macready),
        .out_valid (bus.validout),
        .out_sof   (bus.sofout),
        .out_eof   (bus.eofout),
        .out_odd   (bus.oddout),
        .out_data  (bus.dataout)
    );

endmodule

// File: tb/tb_ethernet_tx_arbiter.sv
// Directed bench for ethernet_tx_arbiter: cycle table for basic frames plus
// hand-written sequences for arbitration, back-pressure, truncation and reset.
module tb_ethernet_tx_arbiter;

    localparam int unsigned IFG  = 3;
    localparam int unsigned MAXH = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ethernet_tx_arbiter_if bus();

    ethernet_tx_arbiter #(.IFG_CYCLES(IFG), .MAXHALF(MAXH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic        arpreq, arpvalid, arpeof;
        logic [15:0] arpdata;
        logic        ipreq, ipvalid, ipeof;
        logic [15:0] ipdata;
        logic        macready;
    } in_t;

    typedef struct packed {
        logic        arpgrant, arpready, ipgrant, ipready;
        logic        validout, sofout, eofout, oddout, lenerr;
        logic [15:0] typeout;
        logic [31:0] dataout;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    typedef struct packed {
        logic        sof, eof, odd;
        logic [15:0] typ;
        logic [31:0] data;
    } word_t;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    int unsigned lenerr_cnt = 0;
    word_t       mon_q[$];
    vec_t        tbl[$];

    always @(negedge clock) begin
        if (!reset) begin
            if (bus.validout && bus.macready)
                mon_q.push_back({bus.sofout, bus.eofout, bus.oddout, bus.typeout, bus.dataout});
            if (bus.lenerr)
                lenerr_cnt++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    function automatic in_t mk_in(input logic [2:0] arp, input logic [15:0] ad,
                                  input logic [2:0] ip, input logic [15:0] id);
        return {arp, ad, ip, id, 1'b1};
    endfunction

    function automatic out_t mk_out(input logic [3:0] g, input logic [4:0] f,
                                    input logic [15:0] ty, input logic [31:0] d);
        return {g, f, ty, d};
    endfunction

    function automatic out_t sample();
        return {bus.arpgrant, bus.arpready, bus.ipgrant, bus.ipready,
                bus.validout, bus.sofout, bus.eofout, bus.oddout, bus.lenerr,
                bus.typeout, bus.dataout};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %h required %h", name, act, exp);
    endtask

    task automatic drive(input in_t v);
        bus.arpreq   = v.arpreq;
        bus.arpvalid = v.arpvalid;
        bus.arpeof   = v.arpeof;
        bus.arpdata  = v.arpdata;
        bus.ipreq    = v.ipreq;
        bus.ipvalid  = v.ipvalid;
        bus.ipeof    = v.ipeof;
        bus.ipdata   = v.ipdata;
        bus.macready = v.macready;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(mk_in(3'b000, 16'h0, 3'b000, 16'h0));
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic push_hw(input logic is_ip, input logic [15:0] d, input logic eof);
        logic rdy;
        logic ok;
        ok = 1'b0;
        if (is_ip) begin
            bus.ipvalid = 1'b1; bus.ipdata = d; bus.ipeof = eof;
        end else begin
            bus.arpvalid = 1'b1; bus.arpdata = d; bus.arpeof = eof;
        end
        for (int t = 0; t < 40 && !ok; t++) begin
            #1;
            rdy = is_ip ? bus.ipready : bus.arpready;
            step();
            ok = rdy;
        end
        check($sformatf("hw_accept_%h", d), 64'(ok), 64'(1));
    endtask

    task automatic end_src();
        bus.arpvalid = 1'b0; bus.arpeof = 1'b0;
        bus.ipvalid  = 1'b0; bus.ipeof  = 1'b0;
    endtask

    task automatic push_frame(input logic is_ip, input int n, input logic [15:0] base);
        for (int k = 0; k < n; k++)
            push_hw(is_ip, base + 16'(k), k == n - 1);
        end_src();
    endtask

    task automatic wait_grant(output int who, output int waited);
        who = -1;
        waited = 0;
        for (int t = 0; t < 60; t++) begin
            if (bus.arpgrant) begin who = 0; break; end
            if (bus.ipgrant)  begin who = 1; break; end
            step();
            waited++;
        end
    endtask

    task automatic wait_words(input int n);
        for (int t = 0; t < 60; t++) begin
            if (mon_q.size() >= n) break;
            step();
        end
    endtask

    initial begin
        int    who;
        int    waited;
        logic  exp_ip;
        word_t w;

        drive(mk_in(3'b000, 16'h0, 3'b000, 16'h0));
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", 64'(sample()), 64'(0));
        reset = 1'b0;

        // arp {req,valid,eof}, data, ip {req,valid,eof}, data ; grants {ag,ar,ig,ir}, {v,sof,eof,odd,lenerr}
        tbl.push_back({mk_in(3'b100, 16'h0000, 3'b000, 16'h0), mk_out(4'b0000, 5'b00000, 16'h0000, 32'h0)});
        tbl.push_back({mk_in(3'b010, 16'h0001, 3'b000, 16'h0), mk_out(4'b1100, 5'b00000, 16'h0806, 32'h0)});
        tbl.push_back({mk_in(3'b010, 16'h0002, 3'b000, 16'h0), mk_out(4'b1100, 5'b00000, 16'h0806, 32'h0)});
        tbl.push_back({mk_in(3'b010, 16'h0003, 3'b000, 16'h0), mk_out(4'b1100, 5'b11000, 16'h0806, 32'h00020001)});
        tbl.push_back({mk_in(3'b011, 16'h0004, 3'b000, 16'h0), mk_out(4'b1100, 5'b00000, 16'h0806, 32'h0)});
        tbl.push_back({mk_in(3'b000, 16'h0000, 3'b000, 16'h0), mk_out(4'b0000, 5'b10100, 16'h0806, 32'h00040003)});
        for (int k = 0; k < 4; k++)
            tbl.push_back({mk_in(3'b100, 16'h0000, 3'b000, 16'h0), mk_out(4'b0000, 5'b00000, 16'h0806, 32'h0)});
        tbl.push_back({mk_in(3'b011, 16'h1234, 3'b000, 16'h0), mk_out(4'b1100, 5'b00000, 16'h0806, 32'h0)});
        tbl.push_back({mk_in(3'b000, 16'h0000, 3'b000, 16'h0), mk_out(4'b0000, 5'b11110, 16'h0806, 32'h00001234)});
        for (int k = 0; k < 4; k++)
            tbl.push_back({mk_in(3'b000, 16'h0000, 3'b100, 16'h0), mk_out(4'b0000, 5'b00000, 16'h0806, 32'h0)});
        tbl.push_back({mk_in(3'b000, 16'h0000, 3'b010, 16'hAAAA), mk_out(4'b0011, 5'b00000, 16'h0800, 32'h0)});
        tbl.push_back({mk_in(3'b000, 16'h0000, 3'b010, 16'hBBBB), mk_out(4'b0011, 5'b00000, 16'h0800, 32'h0)});
        tbl.push_back({mk_in(3'b000, 16'h0000, 3'b011, 16'hCCCC), mk_out(4'b0011, 5'b11000, 16'h0800, 32'hBBBBAAAA)});
        tbl.push_back({mk_in(3'b000, 16'h0000, 3'b000, 16'h0000), mk_out(4'b0000, 5'b10110, 16'h0800, 32'h0000CCCC)});

        for (int r = 0; r < tbl.size(); r++) begin
            drive(tbl[r].i);
            #1;
            check($sformatf("row%0d", r), 64'(sample()), 64'(tbl[r].o));
            step();
        end
        drive(mk_in(3'b000, 16'h0, 3'b000, 16'h0));
        repeat (8) step();

        // simultaneous requests held high: ARP, IP, ARP
        do_reset();
        bus.arpreq = 1'b1;
        bus.ipreq  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_ip = (k == 1);
            wait_grant(who, waited);
            check($sformatf("rr_grant%0d", k), 64'(who), 64'(exp_ip ? 1 : 0));
            check($sformatf("rr_type%0d", k), 64'(bus.typeout), 64'(exp_ip ? 16'h0800 : 16'h0806));
            if (k > 0)
                check($sformatf("rr_gap%0d", k), 64'(waited >= int'(IFG) + 1), 64'(1));
            push_frame(exp_ip, 2, 16'h3000 + 16'(k * 16));
        end
        bus.arpreq = 1'b0;
        bus.ipreq  = 1'b0;
        repeat (8) step();

        // macready held low for 5 cycles with a word pending
        mon_q.delete();
        bus.ipreq = 1'b1;
        wait_grant(who, waited);
        check("stall_grant", 64'(who), 64'(1));
        bus.ipreq = 1'b0;
        push_hw(1'b1, 16'h1001, 1'b0);
        push_hw(1'b1, 16'h1002, 1'b0);
        bus.macready = 1'b0;
        bus.ipvalid = 1'b1; bus.ipdata = 16'h1003; bus.ipeof = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("stall_hold%0d", c), 64'({bus.ipready, bus.validout, bus.dataout}),
                  64'({1'b0, 1'b1, 32'h10021001}));
            step();
        end
        bus.macready = 1'b1;
        push_hw(1'b1, 16'h1003, 1'b0);
        push_hw(1'b1, 16'h1004, 1'b0);
        push_hw(1'b1, 16'h1005, 1'b0);
        push_hw(1'b1, 16'h1006, 1'b1);
        end_src();
        wait_words(3);
        repeat (4) step();
        check("stall_count", 64'(mon_q.size()), 64'(3));
        w = {1'b1, 1'b0, 1'b0, 16'h0800, 32'h10021001};
        check("stall_word0", 64'(mon_q[0]), 64'(w));
        w = {1'b0, 1'b0, 1'b0, 16'h0800, 32'h10041003};
        check("stall_word1", 64'(mon_q[1]), 64'(w));
        w = {1'b0, 1'b1, 1'b0, 16'h0800, 32'h10061005};
        check("stall_word2", 64'(mon_q[2]), 64'(w));
        repeat (6) step();

        // 12-halfword IP frame truncated at MAXHALF=8, ARP waiting
        mon_q.delete();
        lenerr_cnt = 0;
        bus.ipreq = 1'b1;
        wait_grant(who, waited);
        check("trunc_grant", 64'(who), 64'(1));
        bus.ipreq  = 1'b0;
        bus.arpreq = 1'b1;
        push_frame(1'b1, 12, 16'h2001);
        wait_grant(who, waited);
        check("trunc_next_grant", 64'(who), 64'(0));
        check("trunc_lenerr", 64'(lenerr_cnt), 64'(1));
        check("trunc_count", 64'(mon_q.size()), 64'(4));
        for (int k = 0; k < 4; k++) begin
            w = {k == 0, k == 3, 1'b0, 16'h0800,
                 16'h2002 + 16'(2 * k), 16'h2001 + 16'(2 * k)};
            check($sformatf("trunc_word%0d", k), 64'(mon_q[k]), 64'(w));
        end
        bus.arpreq = 1'b0;
        push_frame(1'b0, 1, 16'h4444);
        repeat (8) step();

        // reset between the first and second words of an ARP frame
        mon_q.delete();
        bus.arpreq = 1'b1;
        wait_grant(who, waited);
        check("rst_grant", 64'(who), 64'(0));
        bus.arpreq = 1'b0;
        push_hw(1'b0, 16'h5001, 1'b0);
        push_hw(1'b0, 16'h5002, 1'b0);
        push_hw(1'b0, 16'h5003, 1'b0);
        end_src();
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_outputs", 64'(sample()), 64'(0));
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        mon_q.delete();
        bus.arpreq = 1'b1;
        wait_grant(who, waited);
        check("rst_regrant", 64'(who), 64'(0));
        bus.arpreq = 1'b0;
        push_frame(1'b0, 2, 16'h6001);
        wait_words(1);
        w = {1'b1, 1'b1, 1'b0, 16'h0806, 32'h60026001};
        check("rst_first_word", 64'(mon_q.size() > 0 ? mon_q[0] : '0), 64'(w));
        repeat (6) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
